// File: rtl/cla16_adder.sv
`default_nettype none
// ============================================================================
// Module      : cla16_adder
// Description : 16-bit two-level carry-lookahead adder, registered result.
// Revision    : 1.0 - initial release
// ============================================================================
module cla16_adder (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] A,
  input  logic [15:0] B,
  input  logic        Cin,
  output logic [15:0] sum,
  output logic        Cout
);

  localparam int c_NGROUPS = 4;

  logic [15:0] w_g;
  logic [15:0] w_p;
  logic [15:0] w_sum;
  logic [3:0]  w_gg;
  logic [3:0]  w_pg;
  logic [4:0]  w_cg;   // w_cg[k] is the carry into group k; w_cg[4] is C16

  logic [15:0] r_sum;
  logic        r_cout;

  assign w_g = A & B;
  assign w_p = A ^ B;

  generate
    for (genvar k = 0; k < c_NGROUPS; k++) begin : g_group
      logic [3:0] w_gl;
      logic [3:0] w_pl;
      logic [3:0] w_cl;

      assign w_gl = w_g[4*k +: 4];
      assign w_pl = w_p[4*k +: 4];

      // Carries inside the group come straight from the group carry-in.
      assign w_cl[0] = w_cg[k];
      assign w_cl[1] = w_gl[0] | (w_pl[0] & w_cg[k]);
      assign w_cl[2] = w_gl[1] | (w_pl[1] & w_gl[0]) | (w_pl[1] & w_pl[0] & w_cg[k]);
      assign w_cl[3] = w_gl[2] | (w_pl[2] & w_gl[1]) | (w_pl[2] & w_pl[1] & w_gl[0])
                     | (w_pl[2] & w_pl[1] & w_pl[0] & w_cg[k]);

      assign w_pg[k] = &w_pl;
      assign w_gg[k] = w_gl[3] | (w_pl[3] & w_gl[2]) | (w_pl[3] & w_pl[2] & w_gl[1])
                     | (w_pl[3] & w_pl[2] & w_pl[1] & w_gl[0]);

      assign w_sum[4*k +: 4] = w_pl ^ w_cl;
    end
  endgenerate

  // Second-level lookahead: group carries depend only on GG/PG and Cin.
  assign w_cg[0] = Cin;
  assign w_cg[1] = w_gg[0] | (w_pg[0] & Cin);
  assign w_cg[2] = w_gg[1] | (w_pg[1] & w_gg[0]) | (w_pg[1] & w_pg[0] & Cin);
  assign w_cg[3] = w_gg[2] | (w_pg[2] & w_gg[1]) | (w_pg[2] & w_pg[1] & w_gg[0])
                 | (w_pg[2] & w_pg[1] & w_pg[0] & Cin);
  assign w_cg[4] = w_gg[3] | (w_pg[3] & w_gg[2]) | (w_pg[3] & w_pg[2] & w_gg[1])
                 | (w_pg[3] & w_pg[2] & w_pg[1] & w_gg[0])
                 | (w_pg[3] & w_pg[2] & w_pg[1] & w_pg[0] & Cin);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sum  <= 16'h0000;
      r_cout <= 1'b0;
    end else begin
      r_sum  <= w_sum;
      r_cout <= w_cg[4];
    end
  end

  assign sum  = r_sum;
  assign Cout = r_cout;

endmodule
`default_nettype wire

// File: tb/tb_cla16_adder.sv
`default_nettype none
// ============================================================================
// Module      : tb_cla16_adder
// Description : Scoreboard bench for cla16_adder against an arithmetic model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cla16_adder;

  logic        clk;
  logic        rst;
  logic [15:0] A;
  logic [15:0] B;
  logic        Cin;
  logic [15:0] sum;
  logic        Cout;

  typedef struct {
    logic [16:0] val;
    string       name;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;
  bit   done     = 0;

  cla16_adder dut (
    .clk  (clk),
    .rst  (rst),
    .A    (A),
    .B    (B),
    .Cin  (Cin),
    .sum  (sum),
    .Cout (Cout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: plain 17-bit unsigned addition; reset forces a zero result.
  function automatic logic [16:0] ref_add(input logic r, input logic [15:0] a,
                                          input logic [15:0] b, input logic c);
    if (r) return 17'h0;
    return 17'(a) + 17'(b) + 17'(c);
  endfunction

  task automatic step(input logic r, input logic [15:0] a, input logic [15:0] b,
                      input logic c, input string name);
    exp_t e;
    @(negedge clk);
    rst = r; A = a; B = b; Cin = c;
    @(posedge clk);
    e.val  = ref_add(r, a, b, c);
    e.name = name;
    exp_q.push_back(e);
  endtask

  // Monitor: the result is presented after every edge; check it just after
  // the edge and again late in the cycle after the inputs have moved on.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      checks++;
      if ({Cout, sum} !== e.val) begin
        failures++;
        $display("FAIL %s: got Cout=%b sum=%h, expected Cout=%b sum=%h",
                 e.name, Cout, sum, e.val[16], e.val[15:0]);
      end
      #7;
      checks++;
      if ({Cout, sum} !== e.val) begin
        failures++;
        $display("FAIL %s_hold: got Cout=%b sum=%h, expected Cout=%b sum=%h",
                 e.name, Cout, sum, e.val[16], e.val[15:0]);
      end
    end
  end

  initial begin
    rst = 1'b1; A = 16'h1234; B = 16'hABCD; Cin = 1'b1;

    step(1'b1, 16'hFFFF, 16'hFFFF, 1'b1, "reset0");
    step(1'b1, 16'h5A5A, 16'hA5A5, 1'b1, "reset1");

    step(1'b0, 16'hFF00, 16'h00FF, 1'b0, "prop_cin0");
    step(1'b0, 16'hFF00, 16'h00FF, 1'b1, "prop_cin1");
    step(1'b0, 16'h03C3, 16'h00CF, 1'b1, "mix0493");
    step(1'b0, 16'h1234, 16'h4321, 1'b0, "mix5555");
    step(1'b0, 16'hFFFF, 16'h0001, 1'b0, "wrap");
    step(1'b0, 16'hFFFF, 16'hFFFF, 1'b1, "allones");
    step(1'b0, 16'h0000, 16'h0000, 1'b0, "zero");
    step(1'b0, 16'h0FFF, 16'h0001, 1'b0, "grp_carry");
    step(1'b0, 16'h8000, 16'h8000, 1'b0, "msb_gen");

    for (int i = 0; i < 1000; i++) begin
      logic [15:0] ra, rb;
      logic        rc;
      ra = 16'($urandom);
      rb = 16'($urandom);
      rc = 1'($urandom);
      step(i == 500, ra, rb, rc, (i == 500) ? "mid_reset" : "random");
    end

    step(1'b0, 16'h7FFF, 16'h7FFF, 1'b1, "last");

    // Let the monitor drain the final result, bounded.
    for (int n = 0; n < 4 && exp_q.size() != 0; n++) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain: got %0d results pending, expected 0", exp_q.size());
    end

    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    done = 1;
    $finish;
  end

  initial begin
    #200000;
    if (!done) begin
      $display("FAIL timeout: got no completion, expected completion by 200000");
      failures++;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $fatal(1, "timeout");
    end
  end

endmodule
`default_nettype wire
